// File: rtl/ps2_scancode_fifo.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefix sequences into
// {release, extended, code} events and buffers them in a show-ahead FIFO.
module ps2_scancode_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 2_500_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_en,
    output logic [9:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [7:0]            status_data,
    output logic                  status_stb,
    output logic                  timeout_stb
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXT       = 3'd1,
        ST_BREAK     = 3'd2,
        ST_EXT_BREAK = 3'd3,
        ST_PAUSE     = 3'd4
    } state_t;

    state_t              state_r;
    logic [2:0]          pcnt_r;
    logic [TW-1:0]       idle_cnt_r;
    logic [7:0]          status_data_r;
    logic                status_stb_r;
    logic                timeout_stb_r;
    logic                push_s;
    logic [9:0]          push_data_s;

    logic [9:0]          mem_r [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [DEPTH_LOG2:0] count_r;
    logic [DEPTH_LOG2:0] count_nxt_s;
    logic                out_valid_r;
    logic                overflow_r;
    logic                pop_s;
    logic                full_s;
    logic                wr_en_s;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
            default:                                         is_status = 1'b0;
        endcase
    endfunction

    // Decode which received byte completes an event and what that event is.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = {1'b0, 1'b0, in_data};
        if (in_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_data != 8'hE0 && in_data != 8'hF0 && in_data != 8'hE1 && !is_status(in_data)) begin
                        push_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end
                ST_EXT: begin
                    if (in_data != 8'hE0 && in_data != 8'hF0) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, 1'b1, in_data};
                    end else begin
                        push_s = 1'b0;
                    end
                end
                ST_BREAK: begin
                    push_s      = 1'b1;
                    push_data_s = {1'b1, 1'b0, in_data};
                end
                ST_EXT_BREAK: begin
                    push_s      = 1'b1;
                    push_data_s = {1'b1, 1'b1, in_data};
                end
                ST_PAUSE: begin
                    if (pcnt_r == 3'd1) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, 1'b1, 8'hE1};
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: push_s = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Prefix-sequence FSM with idle timeout and status-byte capture.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pcnt_r        <= 3'd0;
            idle_cnt_r    <= '0;
            status_data_r <= 8'h00;
            status_stb_r  <= 1'b0;
            timeout_stb_r <= 1'b0;
        end else begin
            status_stb_r  <= 1'b0;
            timeout_stb_r <= 1'b0;
            if (in_en) begin
                idle_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (in_data == 8'hE0) begin
                            state_r <= ST_EXT;
                        end else if (in_data == 8'hF0) begin
                            state_r <= ST_BREAK;
                        end else if (in_data == 8'hE1) begin
                            state_r <= ST_PAUSE;
                            pcnt_r  <= 3'd7;
                        end else if (is_status(in_data)) begin
                            status_data_r <= in_data;
                            status_stb_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_EXT: begin
                        if (in_data == 8'hF0) begin
                            state_r <= ST_EXT_BREAK;
                        end else if (in_data == 8'hE0) begin
                            state_r <= ST_EXT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PAUSE: begin
                        pcnt_r <= pcnt_r - 3'd1;
                        // pcnt of 0 here cannot occur normally; treat it as end of sequence
                        if (pcnt_r <= 3'd1) begin
                            state_r <= ST_IDLE;
                            pcnt_r  <= 3'd0;
                        end else begin
                            state_r <= ST_PAUSE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (idle_cnt_r == TO_MAX) begin
                    state_r       <= ST_IDLE;
                    pcnt_r        <= 3'd0;
                    idle_cnt_r    <= '0;
                    timeout_stb_r <= 1'b1;
                end else begin
                    idle_cnt_r <= idle_cnt_r + TW'(1);
                end
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

    assign pop_s   = out_valid_r & out_ready;
    assign full_s  = (count_r == DEPTH);
    assign wr_en_s = push_s & (~full_s | pop_s);

    // Occupancy after this cycle's write/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_nxt_s = count_r - (DEPTH_LOG2 + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + (DEPTH_LOG2 + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (DEPTH_LOG2 + 1)'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            // a drop in the same cycle wins over the clear
            if (push_s & full_s & ~pop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign out_data    = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign out_valid   = out_valid_r;
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign status_data = status_data_r;
    assign status_stb  = status_stb_r;
    assign timeout_stb = timeout_stb_r;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Scoreboard bench for ps2_scancode_fifo (DEPTH_LOG2=2, TIMEOUT=16).
module tb_ps2_scancode_fifo;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_en = 1'b0;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic [7:0] status_data;
    logic       status_stb;
    logic       timeout_stb;

    int vectors = 0;
    int miscompares = 0;
    int stb_pulses = 0;
    logic [9:0] sb[$];

    ps2_scancode_fifo #(.DEPTH_LOG2(2), .TIMEOUT(16)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .in_data     (in_data),
        .in_en       (in_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .status_data (status_data),
        .status_stb  (status_stb),
        .timeout_stb (timeout_stb)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every accepted pop must match the oldest expected event.
    always @(negedge CLOCK_50) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("pop_unexpected", {22'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check_eq("pop_data", {22'd0, out_data}, {22'd0, sb[0]});
                void'(sb.pop_front());
            end
        end
        if (!reset && status_stb) stb_pulses++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        in_data = b;
        in_en   = 1'b1;
        @(posedge CLOCK_50); #1;
        in_en   = 1'b0;
    endtask

    task automatic send_pop(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        in_data   = b;
        in_en     = 1'b1;
        out_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        in_en     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        out_ready = 1'b0;
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        int n;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_status", 32'(status_data), 32'h00);
        check_eq("rst_sstb", 32'(status_stb), 32'd0);
        check_eq("rst_tstb", 32'(timeout_stb), 32'd0);

        // make and break of a plain key
        sb.push_back(10'h01C);
        send_byte(8'h1C);
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_count1", 32'(count), 32'd1);
        send_byte(8'hF0);
        sb.push_back(10'h21C);
        send_byte(8'h1C);
        check_eq("t1_count2", 32'(count), 32'd2);
        check_eq("t1_head", 32'(out_data), 32'h01C);
        drain();

        // extended make/break with a consumer always ready
        out_ready = 1'b1;
        send_byte(8'hE0);
        sb.push_back(10'h175);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        sb.push_back(10'h375);
        send_byte(8'h75);
        repeat (2) @(posedge CLOCK_50);
        #1;
        out_ready = 1'b0;
        check_eq("t2_count", 32'(count), 32'd0);
        check_eq("t2_sb", 32'(sb.size()), 32'd0);

        // pause sequence collapses to one event
        n = stb_pulses;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) sb.push_back(10'h1E1);
            send_byte(pause_seq[i]);
        end
        check_eq("t3_count", 32'(count), 32'd1);
        check_eq("t3_nostb", 32'(stb_pulses - n), 32'd0);
        drain();

        // status byte, then a status value after E0 is a key
        send_byte(8'hAA);
        check_eq("t4_sstb", 32'(status_stb), 32'd1);
        check_eq("t4_sdata", 32'(status_data), 32'hAA);
        check_eq("t4_count", 32'(count), 32'd0);
        @(posedge CLOCK_50); #1;
        check_eq("t4_sstb_low", 32'(status_stb), 32'd0);
        send_byte(8'hE0);
        sb.push_back(10'h1FA);
        send_byte(8'hFA);
        check_eq("t4_nostb", 32'(status_stb), 32'd0);
        check_eq("t4_count1", 32'(count), 32'd1);
        drain();

        // overflow on a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back({2'b00, 8'(8'h1C + i)});
            send_byte(8'(8'h1C + i));
        end
        check_eq("t5_count", 32'(count), 32'd4);
        check_eq("t5_ovf", 32'(overflow), 32'd1);
        check_eq("t5_head", 32'(out_data), 32'h01C);
        @(posedge CLOCK_50); #1 overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1 overflow_clr = 1'b0;
        check_eq("t5_clr", 32'(overflow), 32'd0);
        sb.push_back(10'h021);
        send_pop(8'h21);
        check_eq("t5_pp_count", 32'(count), 32'd4);
        check_eq("t5_pp_ovf", 32'(overflow), 32'd0);
        check_eq("t5_pp_head", 32'(out_data), 32'h01D);
        @(posedge CLOCK_50); #1;
        in_data = 8'h22; in_en = 1'b1; overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1;
        in_en = 1'b0; overflow_clr = 1'b0;
        check_eq("t5_set_wins", 32'(overflow), 32'd1);
        check_eq("t5_count2", 32'(count), 32'd4);
        @(posedge CLOCK_50); #1 overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1 overflow_clr = 1'b0;
        drain();

        // push and pop together while empty: push lands
        sb.push_back(10'h033);
        send_pop(8'h33);
        check_eq("t6_empty_pp", 32'(count), 32'd1);
        drain();

        // prefix timeout
        send_byte(8'hE0);
        n = 0;
        while (!timeout_stb && n < 40) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        check_eq("t7_to_delay", 32'(n), 32'd16);
        @(posedge CLOCK_50); #1;
        check_eq("t7_tstb_low", 32'(timeout_stb), 32'd0);
        sb.push_back(10'h01C);
        send_byte(8'h1C);
        check_eq("t7_head", 32'(out_data), 32'h01C);
        drain();

        // reset mid-sequence
        send_byte(8'hF0);
        @(posedge CLOCK_50); #1 reset = 1'b1;
        @(posedge CLOCK_50); #1 reset = 1'b0;
        check_eq("t8_count", 32'(count), 32'd0);
        sb.push_back(10'h01C);
        send_byte(8'h1C);
        check_eq("t8_head", 32'(out_data), 32'h01C);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
